// File: rtl/oam_dma_sink.sv
// oam_dma_sink: PPU-side sprite OAM owner.
// Serves the CPU OAM DMA stream, CPU ports $2003/$2004 and a renderer read port.
// A post-reset sweep fills every byte with INIT_FILL (BUSY high meanwhile).
// Optional macro OAM_ATTR_MASK_EN: bits [4:2] of sprite attribute bytes
// (address[1:0]==2) are forced to 0 on every write path.
module oam_dma_sink #(
  parameter int                 ADDR_W    = 8,
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  INIT_FILL = 8'hFF
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic [2:0]        CPU_ADDR,
  input  logic              CPU_wren,
  input  logic              CPU_rden,
  input  logic [DATA_W-1:0] CPU_DATA_IN,
  output logic [DATA_W-1:0] CPU_DATA_OUT,
  input  logic              DMA_write,
  input  logic [ADDR_W-1:0] DMA_address,
  input  logic [DATA_W-1:0] DMA_data,
  input  logic              RENDERING,
  input  logic              OAMADDR_CLR,
  input  logic              RENDER_rden,
  input  logic [ADDR_W-1:0] RENDER_ADDR,
  output logic [DATA_W-1:0] RENDER_DATA,
  output logic              BUSY
);

  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic [ADDR_W-1:0]   oamaddr, oamaddr_nxt;
  logic [DATA_W-1:0]   oam [DEPTH];

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata_raw, wdata;
  logic [DATA_W-1:0]   cpu_rdata, render_rdata;
  logic                cpu_wr3, cpu_wr4, cpu_rd4;

  assign cpu_wr3 = CPU_wren && (CPU_ADDR == 3'd3);
  assign cpu_wr4 = CPU_wren && (CPU_ADDR == 3'd4);
  assign cpu_rd4 = CPU_rden && (CPU_ADDR == 3'd4);
  assign BUSY    = (state == CLEAR);

  // Next-state, single OAM write port arbitration and OAMADDR update.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    we          = 1'b0;
    waddr       = ptr;
    wdata_raw   = INIT_FILL;
    oamaddr_nxt = oamaddr;
    case (state)
      CLEAR: begin
        // Sweep owns the write port; CPU/DMA writes are silently dropped.
        we      = 1'b1;
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == LAST) state_nxt = IDLE;
      end
      default: begin
        if (DMA_write) begin
          // DMA is relative to OAMADDR; net OAMADDR change over a full DMA is zero.
          we        = 1'b1;
          waddr     = oamaddr + DMA_address;
          wdata_raw = DMA_data;
        end else if (cpu_wr4 && !RENDERING) begin
          we        = 1'b1;
          waddr     = oamaddr;
          wdata_raw = CPU_DATA_IN;
        end
        if (cpu_wr3)
          oamaddr_nxt = ADDR_W'(CPU_DATA_IN);
        else if (cpu_wr4 && !DMA_write)
          // During rendering the $2004 write is a glitchy +4 with no store.
          oamaddr_nxt = oamaddr + (RENDERING ? ADDR_W'(4) : ADDR_W'(1));
      end
    endcase
    // Sprite-fetch window clobbers OAMADDR regardless of anything else.
    if (OAMADDR_CLR) oamaddr_nxt = '0;
  end

  // Write-path attribute masking (optional).
  always_comb begin
`ifdef OAM_ATTR_MASK_EN
    if (waddr[1:0] == 2'd2) wdata = wdata_raw & ~DATA_W'(8'h1C);
    else                    wdata = wdata_raw;
`else
    wdata = wdata_raw;
`endif
  end

  // Read muxes: INIT_FILL while clearing, otherwise write-first bypass.
  always_comb begin
    cpu_rdata    = oam[oamaddr];
    render_rdata = oam[RENDER_ADDR];
    if (state == CLEAR) begin
      cpu_rdata    = INIT_FILL;
      render_rdata = INIT_FILL;
    end else begin
      if (we && (waddr == oamaddr))     cpu_rdata    = wdata;
      if (we && (waddr == RENDER_ADDR)) render_rdata = wdata;
    end
  end

  // Control state, OAMADDR and registered read data.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state        <= CLEAR;
      ptr          <= '0;
      oamaddr      <= '0;
      CPU_DATA_OUT <= '0;
      RENDER_DATA  <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      oamaddr <= oamaddr_nxt;
      if (cpu_rd4)     CPU_DATA_OUT <= cpu_rdata;
      if (RENDER_rden) RENDER_DATA  <= render_rdata;
    end
  end

  // OAM storage: no reset, initialised only by the sweep.
  always_ff @(posedge CLK) begin
    if (RESET_n && we) oam[waddr] <= wdata;
  end

endmodule
